// File: rtl/fp_multi_adder.sv
// rtl/fp_multi_adder.sv - sequential multi-operand floating-point summation engine
// Ports:
//   clk, reset (async, active-low)
//   start, input_terms, neg_mask : launch a summation; operands captured on the start edge
//   output_z, done, ack          : result held with done=1 until ack
//   busy                         : high whenever not idle
module fp_multi_adder #(
  parameter int EXP_W     = 5,
  parameter int MAN_W     = 10,
  parameter int NUM_TERMS = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NUM_TERMS*(1+EXP_W+MAN_W)-1:0] input_terms,
  input  logic [NUM_TERMS-1:0]                 neg_mask,
  output logic [EXP_W+MAN_W:0]                 output_z,
  output logic                                 done,
  input  logic                                 ack,
  output logic                                 busy
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MW    = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int SW    = MW + 1;             // adder width with carry-out
  localparam int XE_W  = EXP_W + 2;          // signed exponent with headroom
  localparam int LZ_W  = $clog2(MW + 1);
  localparam int IDX_W = 4;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_TERMS*W-1:0]   terms_q, terms_d;
  logic [NUM_TERMS-1:0]     neg_q, neg_d;
  logic [W-1:0]             acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [MW-1:0]            ma_q, ma_d, mb_q, mb_d;
  logic                     sa_q, sa_d, sb_q, sb_d;
  logic signed [XE_W-1:0]   exp_q, exp_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic                     rsign_q, rsign_d;
  logic [MW-1:0]            nm_q, nm_d;
  logic                     spec_q, spec_d;
  logic [W-1:0]             spec_val_q, spec_val_d;
  logic [W-1:0]             out_q, out_d;

  // Right shift that folds every discarded bit into the sticky LSB.
  function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m, input logic [EXP_W-1:0] d);
    logic [MW-1:0] lost;
    if (int'(d) >= MW) begin
      shr_sticky = {{(MW-1){1'b0}}, |m};
    end else begin
      lost       = m & ~({MW{1'b1}} << d);
      shr_sticky = (m >> d) | {{(MW-1){1'b0}}, |lost};
    end
  endfunction

  function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
    lzc = LZ_W'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = LZ_W'(MW - 1 - i);
    end
  endfunction

  // Operand unpacking and rounding temporaries
  logic [W-1:0]           tb_raw, t0_raw;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   sa_u, sb_u;
  logic                   a_inf, b_inf, a_nan, b_nan;
  logic [MW-1:0]          ma_full, mb_full;
  logic [LZ_W-1:0]        lz;
  logic                   rnd_up;
  logic [MAN_W+1:0]       rounded;
  logic signed [XE_W-1:0] exp_r;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           res;

  always_comb begin
    state_d    = state_q;
    terms_d    = terms_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    exp_d      = exp_q;
    sum_d      = sum_q;
    rsign_d    = rsign_q;
    nm_d       = nm_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    out_d      = out_q;

    t0_raw  = terms_q[W-1:0];
    tb_raw  = terms_q[idx_q*W +: W];
    ea      = acc_q[W-2 -: EXP_W];
    fa      = acc_q[MAN_W-1:0];
    sa_u    = acc_q[W-1];
    eb      = tb_raw[W-2 -: EXP_W];
    fb      = tb_raw[MAN_W-1:0];
    sb_u    = tb_raw[W-1] ^ neg_q[idx_q];
    a_inf   = (ea == EXP_ONES) && (fa == '0);
    b_inf   = (eb == EXP_ONES) && (fb == '0);
    a_nan   = (ea == EXP_ONES) && (fa != '0);
    b_nan   = (eb == EXP_ONES) && (fb != '0);
    // A zero exponent flushes the operand (subnormal or zero) to a zero mantissa.
    ma_full = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    mb_full = (eb == '0) ? '0 : {1'b1, fb, 3'b000};

    lz      = lzc(sum_q[MW-1:0]);
    rnd_up  = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    rounded = {1'b0, nm_q[MW-1:3]} + (MAN_W+2)'(rnd_up);
    exp_r   = exp_q + $signed(XE_W'(rounded[MAN_W+1]));
    frac    = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    if (spec_q) begin
      res = spec_val_q;
    end else if ((nm_q == '0) || (exp_r <= 0)) begin
      res = {rsign_q, {(W-1){1'b0}}};
    end else if (exp_r >= $signed(XE_W'(EXP_ONES))) begin
      res = {rsign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      res = {rsign_q, exp_r[EXP_W-1:0], frac};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          terms_d = input_terms;
          neg_d   = neg_mask;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = {t0_raw[W-1] ^ neg_q[0], t0_raw[W-2 -: EXP_W],
                   (t0_raw[W-2 -: EXP_W] == '0) ? {MAN_W{1'b0}} : t0_raw[MAN_W-1:0]};
        idx_d   = IDX_W'(1);
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        sa_d   = sa_u;
        sb_d   = sb_u;
        spec_d = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa_u != sb_u))) begin
          spec_d     = 1'b1;
          spec_val_d = QNAN;
        end else if (a_inf) begin
          spec_d     = 1'b1;
          spec_val_d = {sa_u, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
          spec_d     = 1'b1;
          spec_val_d = {sb_u, EXP_ONES, {MAN_W{1'b0}}};
        end
        if (ea >= eb) begin
          exp_d = $signed(XE_W'(ea));
          ma_d  = ma_full;
          mb_d  = shr_sticky(mb_full, ea - eb);
        end else begin
          exp_d = $signed(XE_W'(eb));
          ma_d  = shr_sticky(ma_full, eb - ea);
          mb_d  = mb_full;
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sa_q == sb_q) begin
          sum_d   = {1'b0, ma_q} + {1'b0, mb_q};
          rsign_d = sa_q;
        end else if (ma_q >= mb_q) begin
          sum_d   = {1'b0, ma_q} - {1'b0, mb_q};
          rsign_d = sa_q;
        end else begin
          sum_d   = {1'b0, mb_q} - {1'b0, ma_q};
          rsign_d = sb_q;
        end
        // A zero sum is -0 only when both operands were negative.
        if (sum_d == '0) rsign_d = sa_q & sb_q;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[SW-1]) begin
          nm_d  = {sum_q[SW-1:2], |sum_q[1:0]};
          exp_d = exp_q + $signed(XE_W'(1));
        end else begin
          nm_d  = sum_q[MW-1:0] << lz;
          exp_d = exp_q - $signed(XE_W'(lz));
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        acc_d = res;
        if (idx_q == IDX_W'(NUM_TERMS - 1)) begin
          out_d   = res;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ALIGN;
        end
      end
      S_DONE: begin
        if (ack) begin
          out_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      terms_q    <= '0;
      neg_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      exp_q      <= '0;
      sum_q      <= '0;
      rsign_q    <= 1'b0;
      nm_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      terms_q    <= terms_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      exp_q      <= exp_d;
      sum_q      <= sum_d;
      rsign_q    <= rsign_d;
      nm_q       <= nm_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      out_q      <= out_d;
    end
  end

  assign output_z = out_q;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_multi_adder.sv
// tb/tb_fp_multi_adder.sv - directed scoreboard bench for fp_multi_adder
module tb_fp_multi_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default half-precision, three-term instance
  logic        rst_n_a, start_a, ack_a, done_a, busy_a;
  logic [47:0] terms_a;
  logic [2:0]  mask_a;
  logic [15:0] z_a;

  // Single-precision, eight-term instance
  logic         rst_n_b, start_b, ack_b, done_b, busy_b;
  logic [255:0] terms_b;
  logic [7:0]   mask_b;
  logic [31:0]  z_b;

  fp_multi_adder dut_a (
    .clk(clk), .reset(rst_n_a), .start(start_a), .input_terms(terms_a),
    .neg_mask(mask_a), .output_z(z_a), .done(done_a), .ack(ack_a), .busy(busy_a)
  );

  fp_multi_adder #(.EXP_W(8), .MAN_W(23), .NUM_TERMS(8)) dut_b (
    .clk(clk), .reset(rst_n_b), .start(start_b), .input_terms(terms_b),
    .neg_mask(mask_b), .output_z(z_b), .done(done_b), .ack(ack_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] sb_a[$];
  logic [31:0] sb_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic start_op_a(input logic [47:0] t, input logic [2:0] m);
    @(negedge clk);
    terms_a = t;
    mask_a  = m;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    terms_a = {16'($urandom), 32'($urandom)};
    mask_a  = 3'($urandom);
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic ack_a_now();
    @(negedge clk);
    ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    check("done_after_ack", 32'(done_a), 32'd0);
    check("busy_after_ack", 32'(busy_a), 32'd0);
  endtask

  task automatic run_a(input string tag, input logic [47:0] t, input logic [2:0] m,
                       input logic [15:0] expz);
    int cyc;
    sb_a.push_back(expz);
    start_op_a(t, m);
    wait_done_a(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd9);
    check(tag, 32'(z_a), 32'(sb_a.pop_front()));
    ack_a_now();
  endtask

  initial begin
    int cyc;
    rst_n_a = 1'b0; start_a = 1'b0; ack_a = 1'b0; terms_a = '0; mask_a = '0;
    rst_n_b = 1'b0; start_b = 1'b0; ack_b = 1'b0; terms_b = '0; mask_b = '0;
    #12;
    check("reset_z", 32'(z_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    run_a("sum_1_1_2",    {16'h4000, 16'h3C00, 16'h3C00}, 3'b000, 16'h4400);
    run_a("cancel",       {16'h4000, 16'h3C00, 16'h3C00}, 3'b100, 16'h0000);
    run_a("tie_to_even",  {16'h0000, 16'h1000, 16'h3C01}, 3'b000, 16'h3C02);
    run_a("tie_keep",     {16'h0000, 16'h1000, 16'h3C00}, 3'b000, 16'h3C00);
    run_a("overflow",     {16'h0000, 16'h7BFF, 16'h7BFF}, 3'b000, 16'h7C00);
    run_a("inf_minus_inf",{16'h3C00, 16'hFC00, 16'h7C00}, 3'b000, 16'h7E00);
    run_a("ftz",          {16'h0000, 16'h0001, 16'h0001}, 3'b000, 16'h0000);
    run_a("sub_norm",     {16'h0000, 16'h3C00, 16'h4000}, 3'b010, 16'h3C00);
    run_a("neg_zeros",    {16'h8000, 16'h8000, 16'h8000}, 3'b000, 16'h8000);
    run_a("inf_plus_fin", {16'h0000, 16'h3C00, 16'h7C00}, 3'b000, 16'h7C00);

    // Reset in the middle of an operation
    start_op_a({16'h4000, 16'h3C00, 16'h3C00}, 3'b000);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("busy_mid_op", 32'(busy_a), 32'd1);
    rst_n_a = 1'b0;
    #1;
    check("abort_z", 32'(z_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    run_a("after_abort", {16'h4000, 16'h3C00, 16'h3C00}, 3'b000, 16'h4400);

    // Hold ack low; result stays put and start in DONE is ignored
    sb_a.push_back(16'h4400);
    start_op_a({16'h4000, 16'h3C00, 16'h3C00}, 3'b000);
    wait_done_a(cyc);
    check("hold_latency", 32'(cyc), 32'd9);
    begin
      logic [15:0] held;
      held = sb_a.pop_front();
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        start_a = 1'b1;
        terms_a = {16'h3C00, 16'h3C00, 16'h3C00};
        check("hold_z", 32'(z_a), 32'(held));
        check("hold_done", 32'(done_a), 32'd1);
      end
    end
    @(negedge clk);
    ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a   = 1'b0;
    start_a = 1'b0;
    check("ack_done", 32'(done_a), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("no_restart", 32'(busy_a), 32'd0);

    // Eight single-precision terms
    sb_b.push_back(32'h4100_0000);
    @(negedge clk);
    terms_b = {8{32'h3F80_0000}};
    mask_b  = 8'h00;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    terms_b = '0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b_latency", 32'(cyc), 32'd29);
    check("b_sum8", z_b, sb_b.pop_front());
    @(negedge clk);
    ack_b = 1'b1;
    @(posedge clk);
    #1;
    ack_b = 1'b0;
    check("b_done_clr", 32'(done_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
